// File: rtl/control_sequencer_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : control_sequencer_if
// Brief    : Instruction handshake, memory handshake and datapath control
//            bundle between the control_sequencer and its environment.
// Revision : 1.0  initial release
// -----------------------------------------------------------------------------
interface control_sequencer_if #(
  parameter int OPC_W    = 3,
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 8
);
  logic                instr_valid;
  logic                instr_ready;
  logic [OPC_W-1:0]    opcode;
  logic                mem_ready;
  logic                R;
  logic                W;
  logic                demux;
  logic [ALU_OP_W-1:0] op;
  logic                WE;
  logic                done;
  logic                err;
  logic [CNT_W-1:0]    instr_cnt;

  // Environment side: issues opcodes and answers memory requests
  modport master (
    output instr_valid, opcode, mem_ready,
    input  instr_ready, R, W, demux, op, WE, done, err, instr_cnt
  );

  // Sequencer side
  modport slave (
    input  instr_valid, opcode, mem_ready,
    output instr_ready, R, W, demux, op, WE, done, err, instr_cnt
  );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : control_sequencer
// Brief    : Multi-cycle control sequencer for the Jericalla datapath.
//            IDLE -> DECODE -> EXEC | MEM | ERR -> IDLE. Drives R/W/demux/op/WE,
//            pulses done on retirement and err on an illegal opcode.
//            Optional feature macro: MEM_TIMEOUT_EN (bounds the MEM wait to
//            TIMEOUT_CYC cycles, then reports err).
// Revision : 1.0  initial release
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int OPC_W       = 3,
  parameter int ALU_OP_W    = 4,
  parameter int CNT_W       = 8
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 15
`endif
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  control_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam logic [OPC_W-1:0]    OPC_ADD   = OPC_W'(0);
  localparam logic [OPC_W-1:0]    OPC_SUB   = OPC_W'(1);
  localparam logic [OPC_W-1:0]    OPC_SLT   = OPC_W'(2);
  localparam logic [OPC_W-1:0]    OPC_STORE = OPC_W'(3);
  localparam logic [OPC_W-1:0]    OPC_LOAD  = OPC_W'(4);

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(4'b0010);
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(4'b0110);
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(4'b0111);
  localparam logic [ALU_OP_W-1:0] ALU_MEM   = ALU_OP_W'(4'b0000);
  localparam logic [ALU_OP_W-1:0] ALU_NONE  = ALU_OP_W'(4'b1111);

  state_t              state_q, state_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                r_q, r_d;
  logic                w_q, w_d;
  logic                demux_q, demux_d;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ALU_OP_W-1:0] op_q, op_d;
  logic                mem_done;

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0]   wait_q, wait_d;
`endif

  // ALU field for a latched opcode; memory ops run the ALU idle-add code 0000
  function automatic logic [ALU_OP_W-1:0] decode_op(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_ADD:             decode_op = ALU_ADD;
      OPC_SUB:             decode_op = ALU_SUB;
      OPC_SLT:             decode_op = ALU_SLT;
      OPC_STORE, OPC_LOAD: decode_op = ALU_MEM;
      default:             decode_op = ALU_NONE;
    endcase
  endfunction

  // A memory access completes in whichever MEM cycle sees mem_ready
  assign mem_done = (state_q == S_MEM) && bus.mem_ready;

  // Next state, latched opcode, retirement counter and wait counter
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    cnt_d   = cnt_q + CNT_W'(done_q | mem_done);
`ifdef MEM_TIMEOUT_EN
    wait_d  = wait_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          opc_d   = bus.opcode;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
`ifdef MEM_TIMEOUT_EN
        wait_d = '0;
`endif
        if (opc_q <= OPC_SLT)                           state_d = S_EXEC;
        else if (opc_q == OPC_STORE || opc_q == OPC_LOAD) state_d = S_MEM;
        else                                            state_d = S_ERR;
      end
      S_EXEC: state_d = S_IDLE;
      S_MEM: begin
        if (bus.mem_ready) begin
          state_d = S_IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        // The last permitted wait cycle has elapsed without mem_ready
        else if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the state being entered, so they are registered
  always_comb begin
    r_d     = 1'b0;
    w_d     = 1'b0;
    demux_d = 1'b0;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    op_d    = ALU_NONE;
    case (state_d)
      S_DECODE: op_d = decode_op(opc_d);
      S_EXEC: begin
        we_d   = 1'b1;
        done_d = 1'b1;
        op_d   = decode_op(opc_d);
      end
      S_MEM: begin
        demux_d = 1'b1;
        op_d    = ALU_MEM;
        w_d     = (opc_d == OPC_STORE);
        r_d     = (opc_d == OPC_LOAD);
      end
      S_ERR:   err_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers; reset lands directly on the IDLE output values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      cnt_q   <= '0;
      r_q     <= 1'b0;
      w_q     <= 1'b0;
      demux_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= ALU_NONE;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      w_q     <= w_d;
      demux_q <= demux_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      op_q    <= op_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // MEM wait-cycle counter, cleared on every MEM entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`endif

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.R           = r_q;
  assign bus.W           = w_q;
  assign bus.demux       = demux_q;
  assign bus.op          = op_q;
  // Load write-back happens in the completion cycle only
  assign bus.WE          = we_q | (r_q & mem_done);
  assign bus.done        = done_q | mem_done;
  assign bus.err         = err_q;
  assign bus.instr_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : tb_control_sequencer
// Brief    : Directed and randomized bench for control_sequencer. A transaction
//            level model expands each opcode into its per-cycle output timeline.
// Revision : 1.0  initial release
// -----------------------------------------------------------------------------
module tb_control_sequencer;
  localparam int CNT_W = 2;
`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  control_sequencer_if #(.OPC_W(3), .ALU_OP_W(4), .CNT_W(CNT_W)) bus ();

  control_sequencer #(
    .OPC_W(3), .ALU_OP_W(4), .CNT_W(CNT_W)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYC(TMO)
`endif
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic             ready;
    logic             r;
    logic             w;
    logic             demux;
    logic             we;
    logic             done;
    logic             err;
    logic [3:0]       op;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } lit_t;

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  int   model_cnt = 0;
  vec_t exp_q[$];
  lit_t lit_q[$];

  // ---------------- model helpers ----------------
  function automatic vec_t ev(input logic rdy, input logic r, input logic w,
                              input logic dm, input logic we, input logic dn,
                              input logic er, input logic [3:0] op);
    vec_t v;
    v.ready = rdy; v.r = r; v.w = w; v.demux = dm; v.we = we;
    v.done = dn; v.err = er; v.op = op; v.cnt = CNT_W'(model_cnt);
    return v;
  endfunction

  function automatic logic [3:0] alu_code(input int opc);
    case (opc)
      0:       return 4'b0010;
      1:       return 4'b0110;
      2:       return 4'b0111;
      3, 4:    return 4'b0000;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic vec_t idle_v();
    return ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
  endfunction

  function automatic vec_t err_v();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111);
  endfunction

  function automatic void retire();
    model_cnt = (model_cnt + 1) % (1 << CNT_W);
  endfunction

  function automatic logic [31:0] field(input int sel);
    case (sel)
      0:       return 32'(bus.instr_ready);
      1:       return 32'(bus.R);
      2:       return 32'(bus.W);
      3:       return 32'(bus.demux);
      4:       return 32'(bus.WE);
      5:       return 32'(bus.done);
      6:       return 32'(bus.err);
      7:       return 32'(bus.op);
      default: return 32'(bus.instr_cnt);
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic v, input logic [2:0] opc, input logic mr, input vec_t e);
    @(posedge clk);
    #1;
    bus.instr_valid = v;
    bus.opcode      = opc;
    bus.mem_ready   = mr;
    if (chk_en) exp_q.push_back(e);
  endtask

  task automatic lit(input string n, input int sel, input logic [31:0] val);
    lit_t l;
    l.name = n; l.sel = sel; l.val = val;
    lit_q.push_back(l);
  endtask

  task automatic idle_step();
    step(1'b0, 3'($urandom), 1'($urandom), idle_v());
  endtask

  // One instruction: gap idle cycles, accept, then the rule-derived timeline.
  // k = cycles mem_ready stays low in MEM; noise drives valid while busy.
  task automatic run_txn(input int opc, input int k, input int gap, input bit noise);
    int waits;
    bit tmo;
    logic nv;
    waits = k;
    tmo   = 1'b0;
    for (int i = 0; i < gap; i++) idle_step();
    step(1'b1, 3'(opc), 1'($urandom), idle_v());
    nv = noise & 1'($urandom);
    step(nv, 3'($urandom), 1'($urandom), ev(0, 0, 0, 0, 0, 0, 0, alu_code(opc)));
    if (opc <= 2) begin
      step(nv, 3'($urandom), 1'($urandom), ev(0, 0, 0, 0, 1, 1, 0, alu_code(opc)));
      retire();
    end else if (opc <= 4) begin
`ifdef MEM_TIMEOUT_EN
      if (k >= TMO) begin
        waits = TMO;
        tmo   = 1'b1;
      end
`endif
      for (int i = 0; i < waits; i++)
        step(nv, 3'($urandom), 1'b0, ev(0, opc == 4, opc == 3, 1, 0, 0, 0, 4'b0000));
      if (tmo) begin
        step(nv, 3'($urandom), 1'($urandom), err_v());
      end else begin
        step(nv, 3'($urandom), 1'b1, ev(0, opc == 4, opc == 3, 1, opc == 4, 1, 0, 4'b0000));
        retire();
      end
    end else begin
      step(nv, 3'($urandom), 1'($urandom), err_v());
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    vec_t a;
    vec_t e;
    lit_t l;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      while (lit_q.size() > 0) begin
        l = lit_q.pop_front();
        got = field(l.sel);
        checks++;
        if (got !== l.val) begin
          errors++;
          $display("FAIL %s: actual=%0h required=%0h at %0t", l.name, got, l.val, $time);
        end
      end
      if (chk_en) begin
        a.ready = bus.instr_ready; a.r = bus.R; a.w = bus.W; a.demux = bus.demux;
        a.we = bus.WE; a.done = bus.done; a.err = bus.err; a.op = bus.op;
        a.cnt = bus.instr_cnt;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL model_empty: actual=%h required=queued expectation at %0t", a, $time);
        end else begin
          e = exp_q.pop_front();
          if (a !== e)begin
            errors++;
            $display("FAIL cycle: actual rdy%b R%b W%b dmx%b WE%b dn%b er%b op%b cnt%0d required rdy%b R%b W%b dmx%b WE%b dn%b er%b op%b cnt%0d at %0t",
                     a.ready, a.r, a.w, a.demux, a.we, a.done, a.err, a.op, a.cnt,
                     e.ready, e.r, e.w, e.demux, e.we, e.done, e.err, e.op, e.cnt, $time);
          end
        end
        checks++;
        if ((bus.WE && bus.W) || (bus.done && bus.err)) begin
          errors++;
          $display("FAIL exclusive: actual WE%b W%b done%b err%b required no WE&W and no done&err at %0t",
                   bus.WE, bus.W, bus.done, bus.err, $time);
        end
      end
    end
  end

  // ---------------- directed then random sequence ----------------
  initial begin
    int opc;
    rst_n           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.opcode      = 3'd0;
    bus.mem_ready   = 1'b0;

    // Asynchronous reset asserted between clock edges
    #13;
    rst_n = 1'b0;
    lit("rst_ready", 0, 32'd1);
    lit("rst_R",     1, 32'd0);
    lit("rst_W",     2, 32'd0);
    lit("rst_demux", 3, 32'd0);
    lit("rst_WE",    4, 32'd0);
    lit("rst_op",    7, 32'hF);
    lit("rst_cnt",   8, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_en = 1'b1;

    // sub with pinned per-cycle values
    step(1'b1, 3'd1, 1'b0, idle_v());
    step(1'b0, 3'd0, 1'b0, ev(0, 0, 0, 0, 0, 0, 0, 4'b0110));
    lit("sub_dec_op", 7, 32'b0110);
    lit("sub_dec_we", 4, 32'd0);
    step(1'b0, 3'd0, 1'b0, ev(0, 0, 0, 0, 1, 1, 0, 4'b0110));
    retire();
    lit("sub_exec_we",   4, 32'd1);
    lit("sub_exec_done", 5, 32'd1);
    idle_step();
    lit("sub_ready", 0, 32'd1);
    lit("sub_cnt",   8, 32'd1);

    // Four more ALU ops: five in total wraps a 2-bit counter to 1
    run_txn(0, 0, 0, 1'b1);
    run_txn(2, 0, 1, 1'b1);
    run_txn(0, 0, 0, 1'b0);
    run_txn(1, 0, 2, 1'b1);
    idle_step();
    lit("wrap_cnt", 8, 32'd1);

    // Store with three wait cycles, load completing immediately
    run_txn(3, 3, 0, 1'b1);
    run_txn(4, 0, 0, 1'b1);
    idle_step();
    lit("mem_cnt", 8, 32'd3);

    // Illegal opcode
    step(1'b1, 3'd5, 1'b0, idle_v());
    step(1'b0, 3'd0, 1'b1, ev(0, 0, 0, 0, 0, 0, 0, 4'b1111));
    step(1'b0, 3'd0, 1'b1, err_v());
    lit("ill_err",  6, 32'd1);
    lit("ill_done", 5, 32'd0);
    idle_step();
    lit("ill_ready", 0, 32'd1);
    lit("ill_cnt",   8, 32'd3);

    // Reset while a store waits in MEM
    step(1'b1, 3'd3, 1'b0, idle_v());
    step(1'b0, 3'd0, 1'b0, ev(0, 0, 0, 0, 0, 0, 0, 4'b0000));
    step(1'b0, 3'd0, 1'b0, ev(0, 0, 1, 1, 0, 0, 0, 4'b0000));
    step(1'b0, 3'd0, 1'b0, ev(0, 0, 1, 1, 0, 0, 0, 4'b0000));
    @(posedge clk);
    #3;
    chk_en          = 1'b0;
    bus.instr_valid = 1'b0;
    bus.mem_ready   = 1'b1;
    rst_n           = 1'b0;
    lit("midrst_ready", 0, 32'd1);
    lit("midrst_W",     2, 32'd0);
    lit("midrst_demux", 3, 32'd0);
    lit("midrst_done",  5, 32'd0);
    lit("midrst_cnt",   8, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    model_cnt = 0;
    #1 chk_en = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      opc = int'($urandom_range(0, 7));
      run_txn(opc, int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), 1'b1);
    end
    idle_step();
    idle_step();
    @(negedge clk);
    #1 chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
